rr_mux_arbiter: RTL and testbench

- Parametrised, registered N:1 multiplexer with round-robin arbitration and valid/ready handshakes on every input and on the output.
- Generalises the 2:1 select mux to N_CH channels of WIDTH bits, with fair arbitration in place of a static select.
- Optional packet mode holds the grant on one channel until its last beat.
- Sits between several producers and one shared consumer, for example a bus or FIFO write port.

---
 rtl/rr_mux_pkg.sv | 24 ++
 rtl/rr_mux_arbiter_pick.sv | 36 +++
 rtl/rr_mux_arbiter.sv | 136 +++++++++++++
 tb/tb_rr_mux_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_pkg
// Description : Shared types and helpers for the round-robin mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_mux_pkg;

  // Arbitration state: FREE re-arbitrates, LOCKED holds the grant on one channel
  typedef enum logic [0:0] {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Width needed to index n items, never less than one bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_mux_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Rotate-priority search; first valid channel at or after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import rr_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0] valid,
  input  logic [CH_W-1:0] ptr,
  output logic            any,
  output logic [CH_W-1:0] idx
);

  logic [CH_W-1:0] w_cand;

  // Scan farthest offset first so the candidate nearest ptr is written last and wins
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      w_cand = CH_W'((int'(ptr) + k) % N_CH);
      if (valid[w_cand]) begin
        any = 1'b1;
        idx = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter
// Description : Registered N:1 mux with round-robin arbitration, valid/ready
//               handshakes and optional packet-level grant locking.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int N_CH        = 4,
  parameter  int WIDTH       = 8,
  parameter  int PACKET_MODE = 0,
  localparam int CH_W        = clog2_min1(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*WIDTH-1:0]  in_data,
  input  logic [N_CH-1:0]        in_last,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [CH_W-1:0]        out_ch,
  output logic                   out_last,
  input  logic                   out_ready
);

  arb_state_t       r_state, w_state_nxt;
  logic [CH_W-1:0]  r_ptr, w_ptr_nxt;
  logic [CH_W-1:0]  r_lock_ch, w_lock_nxt;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [CH_W-1:0]  r_out_ch;
  logic             r_out_last;

  logic             w_pick_any;
  logic [CH_W-1:0]  w_pick_idx;
  logic             w_any_winner;
  logic [CH_W-1:0]  w_winner;
  logic             w_load;
  logic             w_xfer;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_last;

  rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_pick (
    .valid (in_valid),
    .ptr   (r_ptr),
    .any   (w_pick_any),
    .idx   (w_pick_idx)
  );

  // Gating with rst_n keeps every in_ready low while reset is asserted
  assign w_load   = rst_n & (~r_out_valid | out_ready);
  assign w_xfer   = w_load & w_any_winner;
  assign in_ready = w_xfer ? (N_CH'(1) << w_winner) : '0;

  // Winner is the rotate search result when free, otherwise only the locked channel
  always_comb begin
    w_any_winner = w_pick_any;
    w_winner     = w_pick_idx;
    if (r_state == ST_LOCKED) begin
      w_any_winner = in_valid[r_lock_ch];
      w_winner     = r_lock_ch;
    end
  end

  // Steer the winning channel's data and last flag to the output register
  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_winner == CH_W'(i)) begin
        w_sel_data = in_data[i*WIDTH +: WIDTH];
        w_sel_last = in_last[i];
      end
    end
  end

  // Next pointer/state: a non-last packet beat locks, anything else advances ptr past the winner
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_lock_nxt  = r_lock_ch;
    if (w_xfer) begin
      if ((PACKET_MODE != 0) && !w_sel_last) begin
        w_state_nxt = ST_LOCKED;
        w_lock_nxt  = w_winner;
      end else begin
        w_state_nxt = ST_FREE;
        w_ptr_nxt   = (w_winner == CH_W'(N_CH - 1)) ? '0 : w_winner + 1'b1;
      end
    end
  end

  // Arbitration state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FREE;
      r_ptr     <= '0;
      r_lock_ch <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_lock_ch <= w_lock_nxt;
    end
  end

  // Output register: load a granted beat, or empty when loading with nothing granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_sel_data;
        r_out_ch   <= w_winner;
        r_out_last <= w_sel_last;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux_arbiter
// Description : Self-checking bench; dut0 is beat mode, dut1 is packet mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic        out_ready;

  logic [3:0]  in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [7:0]  out_data0, out_data1;
  logic [1:0]  out_ch0, out_ch1;
  logic        out_last0, out_last1;

  beat_t q0[$];
  beat_t q1[$];
  beat_t e;
  int n_cmp = 0;
  int n_bad = 0;

  rr_mux_arbiter #(.N_CH(4), .WIDTH(8), .PACKET_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready0), .out_valid(out_valid0),
    .out_data(out_data0), .out_ch(out_ch0), .out_last(out_last0),
    .out_ready(out_ready)
  );

  rr_mux_arbiter #(.N_CH(4), .WIDTH(8), .PACKET_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready1), .out_valid(out_valid1),
    .out_data(out_data1), .out_ch(out_ch1), .out_last(out_last1),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    in_last   = 4'b0000;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready = 1'b1;
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_last   = 4'b0000;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready = 1'b1;
    q0.delete();
    q1.delete();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
        n_bad++; $display("FAIL reset_out_valid cyc=%0d got %b/%b want 0/0", c, out_valid0, out_valid1);
      end
      n_cmp++;
      if (in_ready0 !== 4'b0000 || in_ready1 !== 4'b0000) begin
        n_bad++; $display("FAIL reset_in_ready cyc=%0d got %b/%b want 0000", c, in_ready0, in_ready1);
      end
      n_cmp++;
      if (out_ch0 !== 2'd0 || out_data0 !== 8'h00 || out_last0 !== 1'b0) begin
        n_bad++; $display("FAIL reset_out_fields ch=%0d data=%h last=%b want 0/00/0", out_ch0, out_data0, out_last0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready0 !== 4'b0001 || in_ready1 !== 4'b0001) begin
      n_bad++; $display("FAIL reset_first_ready got %b/%b want 0001", in_ready0, in_ready1);
    end
    q0.push_back('{ch: 2'd0, data: 8'hA0, last: 1'b0});
    q1.push_back('{ch: 2'd0, data: 8'hA0, last: 1'b0});
    @(posedge clk);
    #1;
    e = q0.pop_front();
    n_cmp++;
    if (out_valid0 !== 1'b1 || out_ch0 !== e.ch || out_data0 !== e.data) begin
      n_bad++; $display("FAIL reset_first_grant0 got v=%b ch=%0d d=%h want ch=%0d d=%h", out_valid0, out_ch0, out_data0, e.ch, e.data);
    end
    e = q1.pop_front();
    n_cmp++;
    if (out_valid1 !== 1'b1 || out_ch1 !== e.ch || out_data1 !== e.data) begin
      n_bad++; $display("FAIL reset_first_grant1 got v=%b ch=%0d d=%h want ch=%0d d=%h", out_valid1, out_ch1, out_data1, e.ch, e.data);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] dv;
    do_reset();
    in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++;
      if (in_ready0 !== (4'b0001 << (k % 4))) begin
        n_bad++; $display("FAIL rr_ready k=%0d got %b want %b", k, in_ready0, 4'b0001 << (k % 4));
      end
      dv = 8'hA0 + 8'(k % 4);
      q0.push_back('{ch: 2'(k % 4), data: dv, last: 1'b0});
      @(posedge clk);
      #1;
      e = q0.pop_front();
      n_cmp++;
      if (out_valid0 !== 1'b1 || out_ch0 !== e.ch || out_data0 !== e.data || out_last0 !== e.last) begin
        n_bad++; $display("FAIL rr_beat k=%0d got v=%b ch=%0d d=%h want ch=%0d d=%h", k, out_valid0, out_ch0, out_data0, e.ch, e.data);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 4'b1111;
    q0.push_back('{ch: 2'd0, data: 8'hA0, last: 1'b0});
    @(posedge clk);
    #1;
    e = q0.pop_front();
    n_cmp++;
    if (out_valid0 !== 1'b1 || out_ch0 !== e.ch || out_data0 !== e.data) begin
      n_bad++; $display("FAIL bp_first got ch=%0d d=%h want ch=%0d d=%h", out_ch0, out_data0, e.ch, e.data);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (in_ready0 !== 4'b0000) begin
        n_bad++; $display("FAIL bp_ready cyc=%0d got %b want 0000", c, in_ready0);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid0 !== 1'b1 || out_ch0 !== 2'd0 || out_data0 !== 8'hA0) begin
        n_bad++; $display("FAIL bp_hold cyc=%0d got v=%b ch=%0d d=%h want 1/0/a0", c, out_valid0, out_ch0, out_data0);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready0 !== 4'b0010) begin
      n_bad++; $display("FAIL bp_release_ready got %b want 0010", in_ready0);
    end
    q0.push_back('{ch: 2'd1, data: 8'hA1, last: 1'b0});
    @(posedge clk);
    #1;
    e = q0.pop_front();
    n_cmp++;
    if (out_valid0 !== 1'b1 || out_ch0 !== e.ch || out_data0 !== e.data) begin
      n_bad++; $display("FAIL bp_no_bubble got v=%b ch=%0d d=%h want ch=%0d d=%h", out_valid0, out_ch0, out_data0, e.ch, e.data);
    end
  endtask

  task automatic test_wrap_skip();
    logic [1:0] seq [4];
    seq = '{2'd2, 2'd0, 2'd2, 2'd0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = (k == 0) ? 4'b0100 : 4'b0101;
      #1;
      q0.push_back('{ch: seq[k], data: 8'hA0 + 8'(seq[k]), last: 1'b0});
      @(posedge clk);
      #1;
      e = q0.pop_front();
      n_cmp++;
      if (out_valid0 !== 1'b1 || out_ch0 !== e.ch || out_data0 !== e.data) begin
        n_bad++; $display("FAIL wrap_beat k=%0d got v=%b ch=%0d d=%h want ch=%0d d=%h", k, out_valid0, out_ch0, out_data0, e.ch, e.data);
      end
    end
  endtask

  task automatic test_packet_lock();
    logic [3:0] vs [10];
    logic [3:0] ls [10];
    logic [2:0] ex [10];
    // ex: {valid, ch}; 3'b0xx means no beat expected
    vs = '{4'b0010, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0101, 4'b0101, 4'b0111, 4'b0111};
    ls = '{4'b0000, 4'b0000, 4'b0010, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0111, 4'b0101};
    ex = '{3'b101, 3'b101, 3'b101, 3'b110, 3'b100, 3'b101, 3'b000, 3'b000, 3'b101, 3'b110};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      in_valid = vs[k];
      in_last  = ls[k];
      #1;
      if (ex[k][2]) begin
        q1.push_back('{ch: ex[k][1:0], data: 8'hA0 + 8'(ex[k][1:0]), last: ls[k][ex[k][1:0]]});
      end else begin
        n_cmp++;
        if (in_ready1 !== 4'b0000) begin
          n_bad++; $display("FAIL pkt_gap_ready k=%0d got %b want 0000", k, in_ready1);
        end
      end
      @(posedge clk);
      #1;
      if (ex[k][2]) begin
        e = q1.pop_front();
        n_cmp++;
        if (out_valid1 !== 1'b1 || out_ch1 !== e.ch || out_data1 !== e.data || out_last1 !== e.last) begin
          n_bad++; $display("FAIL pkt_beat k=%0d got v=%b ch=%0d d=%h l=%b want ch=%0d d=%h l=%b", k, out_valid1, out_ch1, out_data1, out_last1, e.ch, e.data, e.last);
        end
      end else begin
        n_cmp++;
        if (out_valid1 !== 1'b0) begin
          n_bad++; $display("FAIL pkt_gap_valid k=%0d got %b want 0", k, out_valid1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    in_valid = 4'b0010;
    in_last  = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      #1;
      q1.push_back('{ch: 2'd1, data: 8'hA1, last: 1'b0});
      @(posedge clk);
      #1;
      e = q1.pop_front();
      n_cmp++;
      if (out_valid1 !== 1'b1 || out_ch1 !== e.ch || out_data1 !== e.data) begin
        n_bad++; $display("FAIL midrst_beat k=%0d got v=%b ch=%0d d=%h want ch=%0d d=%h", k, out_valid1, out_ch1, out_data1, e.ch, e.data);
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid1 !== 1'b0 || out_ch1 !== 2'd0 || in_ready1 !== 4'b0000) begin
      n_bad++; $display("FAIL midrst_async got v=%b ch=%0d rdy=%b want 0/0/0000", out_valid1, out_ch1, in_ready1);
    end
    in_valid = 4'b0011;
    in_last  = 4'b0011;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready1 !== 4'b0001) begin
      n_bad++; $display("FAIL midrst_ready got %b want 0001", in_ready1);
    end
    q1.push_back('{ch: 2'd0, data: 8'hA0, last: 1'b1});
    @(posedge clk);
    #1;
    e = q1.pop_front();
    n_cmp++;
    if (out_valid1 !== 1'b1 || out_ch1 !== e.ch || out_data1 !== e.data || out_last1 !== e.last) begin
      n_bad++; $display("FAIL midrst_grant got v=%b ch=%0d d=%h want ch=%0d d=%h", out_valid1, out_ch1, out_data1, e.ch, e.data);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_packet_lock();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
